// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_seq
// Purpose  : Sequential signed multiplier using radix-4 (bit-pair) Booth
//            recoding. Each RUN cycle it presents the accumulator and one
//            shifted partial product to the shared 64-bit adder. It then
//            registers the returned sum. The product is ready after WIDTH/2
//            add cycles. The shared adder has no carry-in, so the negated
//            multiplicand is formed here with a local incrementer.
// Ports    : clk          - system clock, rising edge
//            clr          - synchronous active-high reset/abort
//            start        - request, honoured only in IDLE or DONE
//            multiplicand - signed operand M (WIDTH)
//            multiplier   - signed operand Q (WIDTH)
//            add_s        - sum returned by the shared adder (2*WIDTH)
//            add_a        - adder operand a: accumulator, zero outside RUN
//            add_b        - adder operand b: partial product, zero outside RUN
//            busy         - high while in RUN
//            done         - one-cycle pulse when product becomes valid
//            product      - signed product, held until next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
    parameter int WIDTH = 32   // operand width; must be even, 2*WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [2*WIDTH-1:0]   add_s,
    output logic [2*WIDTH-1:0]   add_a,
    output logic [2*WIDTH-1:0]   add_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_STEPS = WIDTH / 2;
    localparam int c_CW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_STEPS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [c_PW-1:0]  r_mx;       // sign-extended M
    logic [c_PW-1:0]  r_nmx;      // -M, modulo 2^c_PW
    logic [WIDTH:0]   r_q;        // {Q, q[-1]}; consumed two bits per step
    logic [c_PW-1:0]  r_acc;
    logic [c_PW-1:0]  r_product;
    logic [c_CW-1:0]  r_count;
    logic             r_busy;
    logic             r_done;

    logic             w_run;
    logic             w_last;
    logic [c_PW-1:0]  w_mx_in;
    logic [c_PW-1:0]  w_nmx_in;
    logic [c_PW-1:0]  w_sel;
    logic [c_PW-1:0]  w_pp;
    logic [c_CW:0]    w_shamt;

    assign w_run  = (r_state == c_ST_RUN);
    assign w_last = (r_count == c_LAST);

    // Negation is done here rather than on the shared adder, which has no
    // carry-in. For M = -2^(WIDTH-1) the result +2^(WIDTH-1) still fits.
    assign w_mx_in  = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
    assign w_nmx_in = ~w_mx_in + c_PW'(1);

    // Booth digit select. The low three bits of r_q always hold the
    // triplet {q[2i+1], q[2i], q[2i-1]} for the current step, because r_q
    // shifts right by two bits every RUN cycle.
    always_comb begin
        w_sel = '0;
        case (r_q[2:0])
            3'b001, 3'b010: w_sel = r_mx;
            3'b011:         w_sel = {r_mx[c_PW-2:0], 1'b0};
            3'b100:         w_sel = {r_nmx[c_PW-2:0], 1'b0};
            3'b101, 3'b110: w_sel = r_nmx;
            default:        w_sel = '0;
        endcase
    end

    // Weight of step i is 4^i; bits shifted past the top are dropped.
    assign w_shamt = {r_count, 1'b0};
    assign w_pp    = w_sel << w_shamt;

    // The adder sees constant zero whenever no add is in progress.
    assign add_a   = w_run ? r_acc : '0;
    assign add_b   = w_run ? w_pp  : '0;

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= c_ST_IDLE;
            r_mx      <= '0;
            r_nmx     <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_mx    <= w_mx_in;
                        r_nmx   <= w_nmx_in;
                        r_q     <= {multiplier, 1'b0};
                        r_acc   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_RUN;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    r_acc   <= add_s;
                    r_count <= r_count + c_CW'(1);
                    r_q     <= {2'b00, r_q[WIDTH:2]};
                    if (w_last) begin
                        r_product <= add_s;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= c_ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_seq
// Purpose  : Self-checking bench for booth_mul_seq. The shared 64-bit adder
//            is modelled as a plain sum. Products and per-cycle adder operands
//            are predicted from signed arithmetic and Booth digit values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

    localparam int WIDTH = 32;
    localparam int STEPS = WIDTH / 2;

    logic               clk = 1'b0;
    logic               clr;
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [2*WIDTH-1:0] add_s;
    logic [2*WIDTH-1:0] add_a;
    logic [2*WIDTH-1:0] add_b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared carry-lookahead adder: no carry-in, carry-out dropped.
    assign add_s = add_a + add_b;

    booth_mul_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_s        (add_s),
        .add_a        (add_a),
        .add_b        (add_b),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    // Signed product modulo 2^64.
    function automatic logic [63:0] model_mul(input logic [31:0] m, input logic [31:0] q);
        longint a;
        longint b;
        a = longint'(signed'(m));
        b = longint'(signed'(q));
        return 64'(a * b);
    endfunction

    // Radix-4 Booth digit of step i: -2*q[2i+1] + q[2i] + q[2i-1], q[-1] = 0.
    function automatic int booth_digit(input logic [31:0] q, input int i);
        int hi;
        int mid;
        int lo;
        hi  = int'(q[2*i+1]);
        mid = int'(q[2*i]);
        lo  = (i == 0) ? 0 : int'(q[2*i-1]);
        return -2 * hi + mid + lo;
    endfunction

    // Called at the falling edge of RUN cycle 0 of an accepted op. It returns
    // at the falling edge of the DONE cycle. If poke_at >= 0, a conflicting
    // start is pulsed during that RUN cycle.
    task automatic op_body(input logic [31:0] m, input logic [31:0] q,
                           input string name, input int poke_at);
        logic [63:0] ma;
        logic [63:0] exp_acc;
        logic [63:0] exp_b;
        logic [63:0] exp_p;
        int d;
        ma      = 64'(signed'(m));
        exp_acc = '0;
        exp_p   = model_mul(m, q);
        for (int i = 0; i < STEPS; i++) begin
            d     = booth_digit(q, i);
            exp_b = (ma * 64'(d)) << (2 * i);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected 1", name, i, busy);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s early done cycle %0d: got %b expected 0", name, i, done);
            end
            checks++;
            if (add_a !== exp_acc) begin
                errors++;
                $display("FAIL %s add_a cycle %0d: got %h expected %h", name, i, add_a, exp_acc);
            end
            checks++;
            if (add_b !== exp_b) begin
                errors++;
                $display("FAIL %s add_b cycle %0d: got %h expected %h", name, i, add_b, exp_b);
            end
            exp_acc = exp_acc + exp_b;
            if (i == poke_at) begin
                start        = 1'b1;
                multiplicand = ~m;
                multiplier   = q + 32'd5;
            end else if (poke_at >= 0 && i == poke_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done cycle: got done=%b busy=%b expected done=1 busy=0", name, done, busy);
        end
        checks++;
        if (product !== exp_p) begin
            errors++;
            $display("FAIL %s product: got %h expected %h", name, product, exp_p);
        end
        checks++;
        if (add_a !== 64'd0 || add_b !== 64'd0) begin
            errors++;
            $display("FAIL %s adder idle in DONE: got a=%h b=%h expected 0", name, add_a, add_b);
        end
    endtask

    // Single op with a one-cycle start pulse, plus a post-DONE check.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          input string name, input int poke_at);
        logic [63:0] exp_p;
        exp_p        = model_mul(m, q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(negedge clk);
        start = 1'b0;
        op_body(m, q, name, poke_at);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== exp_p) begin
            errors++;
            $display("FAIL %s after DONE: got done=%b busy=%b product=%h expected 0 0 %h",
                     name, done, busy, product, exp_p);
        end
    endtask

    task automatic test_reset();
        clr          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (product !== 64'd0) begin
            errors++;
            $display("FAIL reset product: got %h expected 0", product);
        end
        checks++;
        if (add_a !== 64'd0 || add_b !== 64'd0) begin
            errors++;
            $display("FAIL reset adder: got a=%h b=%h expected 0", add_a, add_b);
        end
    endtask

    task automatic test_basic();
        run_op(32'd7, 32'd6, "mul_7x6", -1);
        checks++;
        if (product !== 64'h0000_0000_0000_002A) begin
            errors++;
            $display("FAIL mul_7x6 literal: got %h expected 000000000000002a", product);
        end
    endtask

    task automatic test_negative();
        run_op(32'hFFFF_FFFB, 32'd3, "mul_m5x3", -1);
        checks++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            errors++;
            $display("FAIL mul_m5x3 literal: got %h expected fffffffffffffff1", product);
        end
    endtask

    task automatic test_back_to_back();
        start        = 1'b1;
        multiplicand = 32'h8000_0000;
        multiplier   = 32'h8000_0000;
        @(negedge clk);
        // start stays high; second operands wait on the inputs for the DONE edge
        multiplicand = 32'hFFFF_FFFF;
        multiplier   = 32'hFFFF_FFFF;
        op_body(32'h8000_0000, 32'h8000_0000, "b2b_min", -1);
        checks++;
        if (product !== 64'h4000_0000_0000_0000) begin
            errors++;
            $display("FAIL b2b_min literal: got %h expected 4000000000000000", product);
        end
        @(negedge clk);
        start = 1'b0;
        op_body(32'hFFFF_FFFF, 32'hFFFF_FFFF, "b2b_neg1", -1);
        checks++;
        if (product !== 64'h0000_0000_0000_0001) begin
            errors++;
            $display("FAIL b2b_neg1 literal: got %h expected 0000000000000001", product);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b tail: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_ignore_start();
        run_op(32'd12345, 32'hFFFF_F000, "ignore_start", 5);
    endtask

    task automatic test_clr_abort();
        bit seen_done;
        start        = 1'b1;
        multiplicand = 32'd123456;
        multiplier   = 32'hFFFF_FCEB;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL clr_abort state: got busy=%b done=%b product=%h expected 0 0 0",
                     busy, done, product);
        end
        checks++;
        if (add_a !== 64'd0 || add_b !== 64'd0) begin
            errors++;
            $display("FAIL clr_abort adder: got a=%h b=%h expected 0", add_a, add_b);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL clr_abort residue: got activity=1 expected 0");
        end
        run_op(32'd3, 32'hFFFF_FFFC, "after_clr_3xm4", -1);
        checks++;
        if (product !== 64'hFFFF_FFFF_FFFF_FFF4) begin
            errors++;
            $display("FAIL after_clr_3xm4 literal: got %h expected fffffffffffffff4", product);
        end
    endtask

    task automatic test_random();
        logic [31:0] m;
        logic [31:0] q;
        for (int n = 0; n < 12; n++) begin
            m = $urandom;
            q = $urandom;
            if (n == 0) m = 32'd0;
            if (n == 1) q = 32'd0;
            if (n == 2) m = 32'h8000_0000;
            if (n == 3) q = 32'h7FFF_FFFF;
            run_op(m, q, $sformatf("rand_%0d", n), -1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_back_to_back();
        test_ignore_start();
        test_clr_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential signed multiplier using radix-4 (bit-pair) Booth recoding.
- Sits directly upstream of the 64-bit carry-lookahead adder in the datapath's MUL path. Each cycle it drives the adder's a/b inputs with the accumulator and the next partial product, and registers the adder's sum back.
- Produces the 64-bit product for the HI/LO registers after WIDTH/2 add cycles.
- The shared 64-bit adder has no carry-in, so this block handles all negation internally.

Parameters:
- WIDTH, 32, operand width. Must be even. 2*WIDTH must equal 64, the adder width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicand  input  WIDTH  signed operand M, latched on accepted start.
- multiplier  input  WIDTH  signed operand Q, latched on accepted start.
- add_s  input  2*WIDTH  sum returned combinationally from the 64-bit adder.
- add_a  output  2*WIDTH  adder operand a: the accumulator.
- add_b  output  2*WIDTH  adder operand b: the current partial product.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse when the product becomes valid.
- product  output  2*WIDTH  signed product; held until the next accepted start.

Behaviour:
- Synchronous reset. When clr=1 at a rising edge:
  - state <= IDLE; acc, product, count, latched operands <= 0; busy=0, done=0.
  - clr overrides start and aborts any in-progress RUN with no partial result kept.
- States: IDLE, RUN, DONE.
- Accepted start (state IDLE or DONE, start=1) at edge N:
  - Latch Mx = sign_ext64(M).
  - Latch nMx = two's-complement negation of Mx, using an internal incrementer, not the shared adder.
  - Latch Q with appended q[-1]=0; acc <= 0; count <= 0; state <= RUN.
- start is ignored while in RUN (no restart, no queue).
- RUN cycle i, i = 0 .. WIDTH/2-1:
  - Recode triplet {q[2i+1], q[2i], q[2i-1]}:
    - 000 and 111 -> 0
    - 001 and 010 -> +Mx
    - 011 -> +2Mx
    - 100 -> 2*nMx
    - 101 and 110 -> nMx
  - add_b = selected value << 2i, truncated to 64 bits.
  - add_a = acc.
  - At the edge: acc <= add_s; count <= count+1.
- Single-cycle adder path: add_a/add_b come from registers plus the mux only. add_s is captured on the same edge.
- After the cycle with count = WIDTH/2-1 (edge N+16 for WIDTH=32):
  - product <= add_s; state <= DONE; done=1 for that one cycle; busy=0.
- Latency: start sampled at edge N -> done high and product valid in the cycle following edge N+16, i.e. 16 add cycles.
- DONE: with no start, the state returns to IDLE the next cycle. done is therefore a one-cycle pulse. product holds.
- start asserted in the DONE cycle is accepted: back-to-back operation with no idle gap.
- Outside RUN, add_a=0 and add_b=0, so the adder sees constant zero.
- Arithmetic is modulo 2^64. Any 64-bit truncation or overflow of the adder is discarded; the adder's carry out is unused.
- Edge cases:
  - M = -2^31: nMx = +2^31 is representable in 64 bits, so no special case is needed.
  - M = 0 or Q = 0: the full 16 cycles still run; the result is 0.

Test Plan:
- clr high 2 cycles, then release -> busy=0, done=0, product=0, add_a=add_b=0.
- M=7, Q=6, start 1 cycle -> busy for exactly 16 cycles; done pulses once; product=0x000000000000002A; add_a/add_b track acc/partial product each cycle.
- M=-5 (0xFFFFFFFB), Q=3 -> product=0xFFFFFFFFFFFFFFF1.
- Corner operands, run back-to-back with start held high through DONE:
  - M=Q=0x80000000 -> product=0x4000000000000000.
  - Then M=Q=0xFFFFFFFF -> product=0x0000000000000001.
  - The second op must begin with no idle cycle.
- Start pulsed again at RUN cycle 5 with different operands -> ignored; the original product is delivered at cycle 16.
- clr asserted at RUN cycle 8 -> next cycle IDLE, product=0, no done pulse. A subsequent start of M=3, Q=-4 -> product=0xFFFFFFFFFFFFFFF4.
